// File: rtl/sram_pkg.sv
// Shared types and default geometry for the parameterised SRAM block.
package sram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/sram_mem_array.sv
// Byte-enabled storage array with one write port and one registered read port.
module sram_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [DATA_W/8-1:0]  i_wbe,
    input  logic                 i_re,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [DATA_W-1:0]    o_rdata
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_wbe[b])
                    mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Read register only moves on a read, so it holds the last result.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_rdata <= '0;
        else if (i_re)
            o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/param_sram.sv
// Single-port SRAM with post-reset clear, byte-enabled writes and 1-cycle reads.
module param_sram
    import sram_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ADDR_W = DEF_ADDR_W,
    localparam int DEPTH  = 2**ADDR_W,
    localparam int BE_W   = DATA_W/8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ce,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [BE_W-1:0]   i_be,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);
    localparam int STAGES = 1;

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   init_cnt;
    logic                init_last;
    logic                acc;
    logic                mem_we, mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_be;
    logic [STAGES-1:0]   vld_pipe;

    assign init_last = &init_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_last) state_nxt = ST_IDLE;
            ST_IDLE: state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Reset wins over a request arriving on the same edge.
    always_comb begin
        o_ready   = 1'b0;
        acc       = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = i_addr;
        mem_wdata = i_data;
        mem_be    = i_be;
        case (state)
            ST_INIT: begin
                mem_we    = ~i_reset;
                mem_addr  = init_cnt;
                mem_wdata = '0;
                mem_be    = '1;
            end
            ST_IDLE: begin
                o_ready = 1'b1;
                acc     = i_ce & ~i_reset;
                mem_we  = acc & i_rw;
                mem_re  = acc & ~i_rw;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            init_cnt <= '0;
        else if (state == ST_INIT)
            init_cnt <= init_cnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            vld_pipe <= '0;
        else
            vld_pipe <= STAGES'({vld_pipe, mem_re});
    end

    assign o_valid = vld_pipe[STAGES-1];

    sram_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (mem_we),
        .i_waddr (mem_addr),
        .i_wdata (mem_wdata),
        .i_wbe   (mem_be),
        .i_re    (mem_re),
        .i_raddr (mem_addr),
        .o_rdata (o_data)
    );

endmodule

// File: tb/tb_param_sram.sv
// Directed, table-driven bench for param_sram at DATA_W=16, ADDR_W=4.
module tb_param_sram;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_ce;
    logic              i_rw;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic [1:0]        i_be;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic        ce;
        logic        rw;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[$];

    param_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_rw    (i_rw),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_be    (i_be),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Counts samples with o_ready low, flagging any o_valid seen meanwhile.
    task automatic wait_ready(output int n);
        int vbad;
        n    = 0;
        vbad = 0;
        while (!o_ready && n < 100) begin
            if (o_valid) vbad++;
            n++;
            tick();
        end
        check("valid_during_init", vbad, 0);
    endtask

    function automatic logic [15:0] final_val(input int a);
        case (a)
            3:       return 16'hA55A;
            5:       return 16'hFF34;
            7:       return 16'hBEEF;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        int n;

        i_reset = 1'b1; i_ce = 1'b0; i_rw = 1'b0;
        i_addr = '0; i_data = '0; i_be = '0;
        tick(); tick(); tick();
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);

        // Release reset with a write to addr 2 held on the bus through init.
        i_reset = 1'b0;
        i_ce = 1'b1; i_rw = 1'b1; i_addr = 4'd2; i_data = 16'h1111; i_be = 2'b11;
        wait_ready(n);
        check("init_low_cycles", n, 16);
        i_ce = 1'b0; i_rw = 1'b0;

        for (int a = 0; a < 16; a++)
            tbl.push_back('{1'b1, 1'b0, 4'(a), 16'h0, 2'b00, 1'b1, 16'h0000});
        tbl.push_back('{1'b1, 1'b1, 4'd3, 16'hA55A, 2'b11, 1'b0, 16'h0000});
        tbl.push_back('{1'b1, 1'b0, 4'd3, 16'h0,    2'b00, 1'b1, 16'hA55A});
        tbl.push_back('{1'b1, 1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, 16'hA55A});
        tbl.push_back('{1'b1, 1'b0, 4'd5, 16'h0,    2'b00, 1'b1, 16'h0034});
        tbl.push_back('{1'b1, 1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b0, 16'h0034});
        tbl.push_back('{1'b1, 1'b0, 4'd5, 16'h0,    2'b00, 1'b1, 16'h0034});
        tbl.push_back('{1'b1, 1'b1, 4'd5, 16'hFFFF, 2'b10, 1'b0, 16'h0034});
        tbl.push_back('{1'b1, 1'b0, 4'd5, 16'h0,    2'b00, 1'b1, 16'hFF34});
        tbl.push_back('{1'b1, 1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b0, 16'hFF34});
        tbl.push_back('{1'b1, 1'b0, 4'd7, 16'h0,    2'b00, 1'b1, 16'hBEEF});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 16'h0,    2'b00, 1'b0, 16'hBEEF});
        for (int a = 0; a < 16; a++)
            tbl.push_back('{1'b1, 1'b0, 4'(a), 16'h0, 2'b00, 1'b1, final_val(a)});
        tbl.push_back('{1'b1, 1'b0, 4'd3, 16'h0,    2'b00, 1'b1, 16'hA55A});

        foreach (tbl[i]) begin
            i_ce = tbl[i].ce; i_rw = tbl[i].rw; i_addr = tbl[i].addr;
            i_data = tbl[i].data; i_be = tbl[i].be;
            tick();
            check($sformatf("vec%0d_valid", i), o_valid, tbl[i].ev);
            check($sformatf("vec%0d_data", i), o_data, tbl[i].ed);
        end

        // Reset lands on the same edge that would accept a read of addr 3.
        i_reset = 1'b1; i_ce = 1'b1; i_rw = 1'b0; i_addr = 4'd3;
        tick();
        check("rst_read_valid", o_valid, 0);
        check("rst_read_data", o_data, 0);
        check("rst_read_ready", o_ready, 0);
        i_reset = 1'b0;
        wait_ready(n);
        check("reinit_low_cycles", n, 16);
        tick();
        check("post_reinit_valid", o_valid, 1);
        check("post_reinit_data", o_data, 0);
        i_ce = 1'b0;
        tick();
        check("idle_valid", o_valid, 0);
        check("idle_data_hold", o_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
